// File: rtl/counter_pow_seq.sv
// counter_pow_seq: iterative integer power unit, out_y = a^exp mod 2^OUT_W.
// Right-to-left square-and-multiply with valid/ready handshakes on both sides.
// Optional build macro POW_PIPE_MUL_EN: a single shared multiplier with a
// registered product, so each iteration takes two cycles. Without the macro,
// separate square and multiply product paths give one iteration per cycle.
module counter_pow_seq #(
    parameter int IN_W  = 8,
    parameter int EXP_W = 4,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_a,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_y,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] base_q, base_d;
    logic [EXP_W-1:0] e_q, e_d;
    logic             ovf_q, ovf_d;
    logic             base_ovf_q, base_ovf_d;

`ifdef POW_PIPE_MUL_EN
    // Pipelined variant: one multiplier whose operands alternate between
    // base*base (phase 0) and acc*base (phase 1). The result of the phase 1
    // multiply is captured into acc on the following phase 0; flush_q marks
    // the extra phase 0 that only drains the last pending product.
    logic               phase_q, phase_d;
    logic               flush_q, flush_d;
    logic [OUT_W-1:0]   prod_q, prod_d;
    logic               prod_nz_q, prod_nz_d;
    logic               pend_q, pend_d;
    logic               pend_ovf_q, pend_ovf_d;
    logic [OUT_W-1:0]   mul_x;
    logic [2*OUT_W-1:0] mul_full;

    // Shared multiplier operand select: square in phase 0, acc*base in phase 1
    always_comb begin
        mul_x = phase_q ? acc_q : base_q;
    end

    assign mul_full = {{OUT_W{1'b0}}, mul_x} * {{OUT_W{1'b0}}, base_q};

    // Next-state, datapath and overflow bookkeeping for the two-phase iteration
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        base_d     = base_q;
        e_d        = e_q;
        ovf_d      = ovf_q;
        base_ovf_d = base_ovf_q;
        phase_d    = phase_q;
        flush_d    = flush_q;
        prod_d     = prod_q;
        prod_nz_d  = prod_nz_q;
        pend_d     = pend_q;
        pend_ovf_d = pend_ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    base_d     = OUT_W'(in_a);
                    acc_d      = {{(OUT_W-1){1'b0}}, 1'b1};
                    e_d        = in_exp;
                    ovf_d      = 1'b0;
                    base_ovf_d = 1'b0;
                    phase_d    = 1'b0;
                    flush_d    = 1'b0;
                    prod_d     = '0;
                    prod_nz_d  = 1'b0;
                    pend_d     = 1'b0;
                    pend_ovf_d = 1'b0;
                    state_d    = (in_exp == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (!phase_q) begin
                    if (pend_q) begin
                        acc_d  = prod_q;
                        ovf_d  = ovf_q | pend_ovf_q;
                        pend_d = 1'b0;
                    end
                    if (flush_q) begin
                        flush_d = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        prod_d    = mul_full[OUT_W-1:0];
                        prod_nz_d = (mul_full[2*OUT_W-1:OUT_W] != '0);
                        phase_d   = 1'b1;
                    end
                end else begin
                    base_d     = prod_q;
                    base_ovf_d = base_ovf_q | prod_nz_q;
                    if (e_q[0]) begin
                        prod_d     = mul_full[OUT_W-1:0];
                        pend_d     = 1'b1;
                        pend_ovf_d = base_ovf_q | (mul_full[2*OUT_W-1:OUT_W] != '0);
                    end
                    e_d     = e_q >> 1;
                    phase_d = 1'b0;
                    if ((e_q >> 1) == '0) begin
                        flush_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pipeline-only registers, cleared asynchronously with the rest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= 1'b0;
            flush_q    <= 1'b0;
            prod_q     <= '0;
            prod_nz_q  <= 1'b0;
            pend_q     <= 1'b0;
            pend_ovf_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            flush_q    <= flush_d;
            prod_q     <= prod_d;
            prod_nz_q  <= prod_nz_d;
            pend_q     <= pend_d;
            pend_ovf_q <= pend_ovf_d;
        end
    end
`else
    // Single-cycle variant: independent square and acc*base product paths
    logic [2*OUT_W-1:0] sq_full;
    logic [2*OUT_W-1:0] mul_full;

    assign sq_full  = {{OUT_W{1'b0}}, base_q} * {{OUT_W{1'b0}}, base_q};
    assign mul_full = {{OUT_W{1'b0}}, acc_q} * {{OUT_W{1'b0}}, base_q};

    // Next-state and datapath: one square-and-multiply step per RUN cycle
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        base_d     = base_q;
        e_d        = e_q;
        ovf_d      = ovf_q;
        base_ovf_d = base_ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    base_d     = OUT_W'(in_a);
                    acc_d      = {{(OUT_W-1){1'b0}}, 1'b1};
                    e_d        = in_exp;
                    ovf_d      = 1'b0;
                    base_ovf_d = 1'b0;
                    state_d    = (in_exp == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (e_q[0]) begin
                    acc_d = mul_full[OUT_W-1:0];
                    ovf_d = ovf_q | base_ovf_q | (mul_full[2*OUT_W-1:OUT_W] != '0);
                end
                base_d     = sq_full[OUT_W-1:0];
                base_ovf_d = base_ovf_q | (sq_full[2*OUT_W-1:OUT_W] != '0);
                e_d        = e_q >> 1;
                if ((e_q >> 1) == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
`endif

    // Core state and datapath registers; reset discards any job in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            base_q     <= '0;
            e_q        <= '0;
            ovf_q      <= 1'b0;
            base_ovf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            base_q     <= base_d;
            e_q        <= e_d;
            ovf_q      <= ovf_d;
            base_ovf_q <= base_ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_y     = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_counter_pow_seq.sv
// Directed testbench for counter_pow_seq with default parameters.
module tb_counter_pow_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [3:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic        out_ovf;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int lat;

    counter_pow_seq #(.IN_W(8), .EXP_W(4), .OUT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and on mismatch count and report it
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present one operand pair for a single accept edge
    task automatic applyStimulus(input logic [7:0] a, input logic [3:0] x);
        @(negedge clk);
        in_a     = a;
        in_exp   = x;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid, bounded
    task automatic waitDone(output int edges);
        edges = 0;
        while (!out_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    // Pulse out_ready for one edge and confirm the unit is back in IDLE
    task automatic releaseResult(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Complete job with hand-computed result, overflow and latency
    task automatic doJob(input string tag, input logic [7:0] a, input logic [3:0] x,
                         input logic [31:0] exp_y, input logic exp_ovf, input int exp_lat);
        int edges;
        applyStimulus(a, x);
        waitDone(edges);
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_lat"}, 64'(edges), 64'(exp_lat));
        checkOutput({tag, "_y"}, 64'(out_y), 64'(exp_y));
        checkOutput({tag, "_ovf"}, 64'(out_ovf), 64'(exp_ovf));
        releaseResult(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_exp    = '0;
        out_ready = 1'b0;
        #12;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_y", 64'(out_y), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        doJob("p3e4", 8'd3, 4'd4, 32'd81, 1'b0, 3);
        doJob("p255e4", 8'd255, 4'd4, 32'hFC05FC01, 1'b0, 3);
        doJob("p255e5", 8'd255, 4'd5, 32'h09F604FF, 1'b1, 3);
        doJob("p2e15", 8'd2, 4'd15, 32'h00008000, 1'b0, 4);
        doJob("p0e0", 8'd0, 4'd0, 32'd1, 1'b0, 0);
        doJob("p0e9", 8'd0, 4'd9, 32'd0, 1'b0, 4);
        doJob("p1e15", 8'd1, 4'd15, 32'd1, 1'b0, 4);
        doJob("p16e8", 8'd16, 4'd8, 32'd0, 1'b1, 4);

        // Backpressure: result held while out_ready is low, in_valid ignored
        applyStimulus(8'd7, 4'd3);
        waitDone(lat);
        checkOutput("bp_lat", 64'(lat), 64'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 8'd9;
            in_exp   = 4'd2;
            @(posedge clk);
            #1;
            checkOutput("bp_y", 64'(out_y), 64'd343);
            checkOutput("bp_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp_ovf", 64'(out_ovf), 64'd0);
        releaseResult("bp");
        checkOutput("bp_valid_low", 64'(out_valid), 64'd0);

        // Asynchronous reset in the middle of a long job
        applyStimulus(8'd255, 4'd15);
        @(posedge clk);
        #2;
        checkOutput("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_y", 64'(out_y), 64'd0);
        checkOutput("mid_rst_ovf", 64'(out_ovf), 64'd0);
        checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        doJob("post_rst", 8'd2, 4'd3, 32'd8, 1'b0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
